// File: rtl/tone_scheduler_pkg.sv
// Shared types and constants for the tone scheduler: FSM state encoding,
// tone index width, melody start note and a timer-width helper.
package tone_scheduler_pkg;

  localparam int NUM_W = 2;

  // Game-over melody starts on the highest note and walks downwards.
  localparam logic [NUM_W-1:0] MELODY_START = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_TONE = 3'd1,
    S_GAP  = 3'd2,
    PLAYER = 3'd3,
    OVER   = 3'd4
  } state_e;

  // Width needed to hold the largest cycle count; never narrower than one bit.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/tone_scheduler_if.sv
// Bundle of the Simon handshake, player buttons, game-over level and the
// shared tone/LED outputs. The scheduler is the slave; its driver is the master.
interface tone_scheduler_if;
  import tone_scheduler_pkg::*;

  logic             simon_turn;
  logic             simon_req;
  logic [NUM_W-1:0] simon_num;
  logic             simon_ack;
  logic             player_valid;
  logic [NUM_W-1:0] player_num;
  logic             game_over;
  logic [NUM_W-1:0] num;
  logic             pressed;
  logic             busy;

  modport master (
    output simon_turn, simon_req, simon_num, player_valid, player_num, game_over,
    input  simon_ack, num, pressed, busy
  );

  modport slave (
    input  simon_turn, simon_req, simon_num, player_valid, player_num, game_over,
    output simon_ack, num, pressed, busy
  );
endinterface

// File: rtl/tone_scheduler_tone_timer.sv
// Loadable down-counter shared by the tone, gap and melody-step phases.
// Load wins over enable; the count holds at zero rather than wrapping.
module tone_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: reload, decrement toward zero, or hold.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = value;
    end else if (en && (count_q != {W{1'b0}})) begin
      count_d = count_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == {W{1'b0}});

endmodule

// File: rtl/tone_scheduler.sv
// Arbitrates the shared tone/LED path between Simon playback, player button
// presses and the game-over melody. Game over always wins; Simon tones are
// timed (tone + silent gap) and acknowledged with a one-cycle pulse.
// All outputs are registered from the next-state decode so busy and pressed
// line up with the state they describe.
module tone_scheduler
  import tone_scheduler_pkg::*;
#(
  parameter int TONE_CYCLES      = 25_000_000,
  parameter int GAP_CYCLES       = 12_500_000,
  parameter int OVER_STEP_CYCLES = 10_000_000
) (
  input  logic              clk,
  input  logic              reset,
  tone_scheduler_if.slave   bus
);

  localparam int TW = timer_width(TONE_CYCLES, GAP_CYCLES, OVER_STEP_CYCLES);

  localparam logic [TW-1:0] TONE_LOAD = TW'(TONE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] STEP_LOAD = TW'(OVER_STEP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic             pressed_q, pressed_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;

  logic             timer_load_s;
  logic [TW-1:0]    timer_value_s;
  logic             timer_en_s;
  logic             timer_zero_s;

  tone_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load_s),
    .value (timer_value_s),
    .en    (timer_en_s),
    .zero  (timer_zero_s)
  );

  // Next-state, latched tone index, timer control and registered-output decode.
  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    ack_d         = 1'b0;
    timer_load_s  = 1'b0;
    timer_value_s = {TW{1'b0}};
    timer_en_s    = 1'b0;

    case (state_q)
      IDLE: begin
        num_d = {NUM_W{1'b0}};
        if (bus.game_over) begin
          state_d       = OVER;
          num_d         = MELODY_START;
          timer_load_s  = 1'b1;
          timer_value_s = STEP_LOAD;
        end else if (bus.simon_turn && bus.simon_req && !ack_q) begin
          // ack_q still high means this req belongs to the tone just finished.
          state_d       = S_TONE;
          num_d         = bus.simon_num;
          timer_load_s  = 1'b1;
          timer_value_s = TONE_LOAD;
        end else if (!bus.simon_turn && bus.player_valid) begin
          state_d = PLAYER;
          num_d   = bus.player_num;
        end else begin
          state_d = IDLE;
        end
      end

      S_TONE: begin
        if (bus.game_over) begin
          state_d       = OVER;
          num_d         = MELODY_START;
          timer_load_s  = 1'b1;
          timer_value_s = STEP_LOAD;
        end else if (timer_zero_s) begin
          state_d       = S_GAP;
          num_d         = {NUM_W{1'b0}};
          timer_load_s  = 1'b1;
          timer_value_s = GAP_LOAD;
        end else begin
          timer_en_s = 1'b1;
        end
      end

      S_GAP: begin
        num_d = {NUM_W{1'b0}};
        if (bus.game_over) begin
          state_d       = OVER;
          num_d         = MELODY_START;
          timer_load_s  = 1'b1;
          timer_value_s = STEP_LOAD;
        end else if (timer_zero_s) begin
          state_d = IDLE;
          ack_d   = 1'b1;
        end else begin
          timer_en_s = 1'b1;
        end
      end

      PLAYER: begin
        // num_q keeps the button latched at entry; later changes are ignored.
        if (bus.game_over) begin
          state_d       = OVER;
          num_d         = MELODY_START;
          timer_load_s  = 1'b1;
          timer_value_s = STEP_LOAD;
        end else if (!bus.player_valid || bus.simon_turn) begin
          state_d = IDLE;
          num_d   = {NUM_W{1'b0}};
        end else begin
          state_d = PLAYER;
        end
      end

      OVER: begin
        if (!bus.game_over) begin
          state_d = IDLE;
          num_d   = {NUM_W{1'b0}};
        end else if (timer_zero_s) begin
          // Melody walks 3,2,1,0 and wraps back to 3 via 2-bit underflow.
          num_d         = num_q - 2'd1;
          timer_load_s  = 1'b1;
          timer_value_s = STEP_LOAD;
        end else begin
          timer_en_s = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        num_d   = {NUM_W{1'b0}};
      end
    endcase

    case (state_d)
      S_TONE, PLAYER, OVER: pressed_d = 1'b1;
      default:              pressed_d = 1'b0;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers, cleared by the asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      num_q     <= {NUM_W{1'b0}};
      pressed_q <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      pressed_q <= pressed_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
    end
  end

  assign bus.num       = num_q;
  assign bus.pressed   = pressed_q;
  assign bus.busy      = busy_q;
  assign bus.simon_ack = ack_q;

endmodule

// File: tb/tb_tone_scheduler.sv
// Directed testbench for tone_scheduler with short timing parameters.
// Inputs change just after a falling edge; outputs are sampled on the next
// falling edge, i.e. one rising edge later. Observed vector is
// {pressed, num[1:0], busy, simon_ack}.
module tb_tone_scheduler;

  localparam int TONE = 4;
  localparam int GAP  = 2;
  localparam int STEP = 3;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  tone_scheduler_if bus ();

  tone_scheduler #(
    .TONE_CYCLES      (TONE),
    .GAP_CYCLES       (GAP),
    .OVER_STEP_CYCLES (STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {bus.pressed, bus.num, bus.busy, bus.simon_ack};
  endfunction

  task automatic idle_inputs();
    bus.simon_turn   = 1'b0;
    bus.simon_req    = 1'b0;
    bus.simon_num    = 2'd0;
    bus.player_valid = 1'b0;
    bus.player_num   = 2'd0;
    bus.game_over    = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    idle_inputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    got = obs();
    n_cmp++;
    if (got !== 5'b0_00_0_0) begin
      n_err++;
      $display("FAIL reset_state: got %b expected %b", got, 5'b0_00_0_0);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    got = obs();
    n_cmp++;
    if (got !== 5'b0_00_0_0) begin
      n_err++;
      $display("FAIL after_reset_idle: got %b expected %b", got, 5'b0_00_0_0);
    end
  endtask

  task automatic test_simon_tone();
    logic [4:0] exp_tab [0:9];
    logic [4:0] got;
    // 4 tone cycles, 2 gap cycles, ack cycle, then silence (req dropped after ack).
    exp_tab = '{5'b1_10_1_0, 5'b1_10_1_0, 5'b1_10_1_0, 5'b1_10_1_0,
                5'b0_00_1_0, 5'b0_00_1_0, 5'b0_00_0_1,
                5'b0_00_0_0, 5'b0_00_0_0, 5'b0_00_0_0};
    bus.simon_turn = 1'b1;
    bus.simon_req  = 1'b1;
    bus.simon_num  = 2'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      got = obs();
      n_cmp++;
      if (got !== exp_tab[i]) begin
        n_err++;
        $display("FAIL simon_tone[%0d]: got %b expected %b", i, got, exp_tab[i]);
      end
      // req is still high through the ack cycle; released right after it.
      if (i == 7) bus.simon_req = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_tone();
    logic [4:0] got;
    bus.simon_turn = 1'b1;
    bus.simon_req  = 1'b1;
    bus.simon_num  = 2'd3;
    repeat (2) @(negedge clk);
    got = obs();
    n_cmp++;
    if (got !== 5'b1_11_1_0) begin
      n_err++;
      $display("FAIL mid_tone_active: got %b expected %b", got, 5'b1_11_1_0);
    end
    #2 reset = 1'b0;
    #1 got = obs();
    n_cmp++;
    if (got !== 5'b0_00_0_0) begin
      n_err++;
      $display("FAIL async_reset: got %b expected %b", got, 5'b0_00_0_0);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    got = obs();
    n_cmp++;
    if (got !== 5'b0_00_0_0) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b expected %b", got, 5'b0_00_0_0);
    end
  endtask

  task automatic test_player();
    logic [4:0] got;
    bus.simon_turn   = 1'b0;
    bus.player_valid = 1'b1;
    bus.player_num   = 2'd1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      got = obs();
      n_cmp++;
      if (i < 5) begin
        if (got !== 5'b1_01_1_0) begin
          n_err++;
          $display("FAIL player_press[%0d]: got %b expected %b", i, got, 5'b1_01_1_0);
        end
      end else begin
        if (got !== 5'b0_00_0_0) begin
          n_err++;
          $display("FAIL player_release: got %b expected %b", got, 5'b0_00_0_0);
        end
      end
      if (i == 1) bus.player_num = 2'd3;
      if (i == 4) bus.player_valid = 1'b0;
    end
    idle_inputs();
  endtask

  task automatic test_player_ignored();
    logic [4:0] got;
    bus.simon_turn   = 1'b1;
    bus.player_valid = 1'b1;
    bus.player_num   = 2'd2;
    repeat (2) @(negedge clk);
    got = obs();
    n_cmp++;
    if (got !== 5'b0_00_0_0) begin
      n_err++;
      $display("FAIL player_in_simon_turn: got %b expected %b", got, 5'b0_00_0_0);
    end
    bus.simon_turn = 1'b0;
    @(negedge clk);
    got = obs();
    n_cmp++;
    if (got !== 5'b1_10_1_0) begin
      n_err++;
      $display("FAIL player_accept: got %b expected %b", got, 5'b1_10_1_0);
    end
    bus.simon_turn = 1'b1;
    @(negedge clk);
    got = obs();
    n_cmp++;
    if (got !== 5'b0_00_0_0) begin
      n_err++;
      $display("FAIL simon_turn_preempt: got %b expected %b", got, 5'b0_00_0_0);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_game_over();
    logic [4:0] got;
    logic [1:0] exp_num;
    bus.simon_turn = 1'b1;
    bus.simon_req  = 1'b1;
    bus.simon_num  = 2'd1;
    repeat (2) @(negedge clk);
    got = obs();
    n_cmp++;
    if (got !== 5'b1_01_1_0) begin
      n_err++;
      $display("FAIL tone_before_over: got %b expected %b", got, 5'b1_01_1_0);
    end
    bus.game_over = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      exp_num = 2'(3 - ((i / STEP) % 4));
      got = obs();
      n_cmp++;
      if (got !== {1'b1, exp_num, 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL melody[%0d]: got %b expected %b", i, got, {1'b1, exp_num, 1'b1, 1'b0});
      end
    end
    bus.game_over = 1'b0;
    bus.simon_req = 1'b0;
    @(negedge clk);
    got = obs();
    n_cmp++;
    if (got !== 5'b0_00_0_0) begin
      n_err++;
      $display("FAIL over_release: got %b expected %b", got, 5'b0_00_0_0);
    end
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic test_same_cycle();
    logic [4:0] got;
    bus.simon_turn = 1'b1;
    bus.simon_req  = 1'b1;
    bus.simon_num  = 2'd2;
    bus.game_over  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = obs();
      n_cmp++;
      if (got !== 5'b1_11_1_0) begin
        n_err++;
        $display("FAIL same_cycle_over[%0d]: got %b expected %b", i, got, 5'b1_11_1_0);
      end
    end
    bus.game_over = 1'b0;
    bus.simon_req = 1'b0;
    @(negedge clk);
    got = obs();
    n_cmp++;
    if (got !== 5'b0_00_0_0) begin
      n_err++;
      $display("FAIL same_cycle_release: got %b expected %b", got, 5'b0_00_0_0);
    end
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    test_reset();
    test_simon_tone();
    test_reset_mid_tone();
    test_player();
    test_player_ignored();
    test_game_over();
    test_same_cycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
